// File: rtl/adc_frontend_pkg.sv
// Shared encodings and sizing helpers for the ADC front-end filter.
// Imported by adc_frontend_filter and adc_chan_accum.
package adc_frontend_pkg;

    localparam int unsigned ADC_W          = 16;
    localparam int unsigned CUR_OFFSET_DEF = 32768;

    localparam logic CH_VOLT = 1'b0;
    localparam logic CH_CURR = 1'b1;

    typedef enum logic {
        ACQ     = 1'b0,
        PUBLISH = 1'b1
    } fsm_state_e;

    // Accumulator width for 2^avg_log2 samples; signed sums carry one extra bit.
    function automatic int unsigned acc_width(input int unsigned avg_log2, input bit is_signed);
        return ADC_W + avg_log2 + (is_signed ? 32'd1 : 32'd0);
    endfunction

endpackage

// File: rtl/adc_chan_accum.sv
// Per-channel boxcar accumulator: sums up to 2^N_LOG2 accepted samples and
// discards any further samples until cleared.
module adc_chan_accum
    import adc_frontend_pkg::*;
#(
    parameter int unsigned N_LOG2    = 4,
    parameter int unsigned IN_W      = ADC_W,
    parameter bit          IS_SIGNED = 1'b0,
    parameter int unsigned ACC_W     = acc_width(N_LOG2, IS_SIGNED)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             acc_en_i,
    input  logic             clr_i,
    input  logic [IN_W-1:0]  data_i,
    output logic [ACC_W-1:0] sum_o,
    output logic             full_o,
    output logic             last_o
);

    localparam int unsigned      CNT_W  = N_LOG2 + 1;
    localparam logic [CNT_W-1:0] CNT_N  = CNT_W'(1 << N_LOG2);
    localparam logic [CNT_W-1:0] CNT_NM1 = CNT_W'((1 << N_LOG2) - 1);

    logic [ACC_W-1:0] sum_q, sum_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ACC_W-1:0] ext;

    always_comb begin
        if (IS_SIGNED) begin
            ext = ACC_W'($signed(data_i));
        end else begin
            ext = ACC_W'(data_i);
        end
    end

    assign full_o = (cnt_q == CNT_N);
    // High while the sample that fills this channel is being accepted.
    assign last_o = acc_en_i && !clr_i && (cnt_q == CNT_NM1);
    assign sum_o  = sum_q;

    always_comb begin
        sum_d = sum_q;
        cnt_d = cnt_q;
        if (clr_i) begin
            sum_d = '0;
            cnt_d = '0;
        end else if (acc_en_i && !full_o) begin
            sum_d = sum_q + ext;
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q <= '0;
            cnt_q <= '0;
        end else begin
            sum_q <= sum_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/adc_frontend_filter.sv
// ADC front-end: averages interleaved voltage/current samples, converts current
// to signed 0.1 A units, publishes a coherent pair and flags a stalled stream.
module adc_frontend_filter
    import adc_frontend_pkg::*;
#(
    parameter int unsigned AVG_LOG2    = 4,
    parameter int unsigned CUR_OFFSET  = CUR_OFFSET_DEF,
    parameter int unsigned I_DEADBAND  = 2,
    parameter int unsigned TIMEOUT_CYC = 100000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    adc_valid,
    input  logic                    adc_chan,
    input  logic [ADC_W-1:0]        adc_data,
    output logic                    adc_ready,
    output logic [ADC_W-1:0]        voltage,
    output logic signed [ADC_W-1:0] current,
    output logic                    out_valid,
    output logic                    stale
);

    localparam int unsigned VW     = acc_width(AVG_LOG2, 1'b0);
    localparam int unsigned IW     = acc_width(AVG_LOG2, 1'b1);
    localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT_CYC);
    localparam logic [IDLE_W-1:0] IDLE_HIT = IDLE_W'(TIMEOUT_CYC - 1);
    localparam logic signed [16:0] DB      = 17'(I_DEADBAND);

    fsm_state_e               state_q;
    logic                     ready_q;
    logic [IDLE_W-1:0]        idle_q, idle_d;
    logic                     pub_q;
    logic [ADC_W-1:0]         v_avg_q;
    logic signed [ADC_W-1:0]  i_avg_q;
    logic [ADC_W-1:0]         volt_q;
    logic signed [ADC_W-1:0]  curr_q;
    logic                     out_valid_q;
    logic                     stale_q;

    logic                     accept, v_en, i_en, clr, hit, done;
    logic signed [16:0]       i_diff;
    logic signed [ADC_W-1:0]  i_samp;
    logic [VW-1:0]            v_sum;
    logic signed [IW-1:0]     i_sum;
    logic                     v_full, v_last, i_full, i_last;
    logic signed [IW-1:0]     i_shift;
    logic signed [ADC_W-1:0]  i_sat, i_db;
    logic signed [16:0]       i_ext;
    logic [ADC_W-1:0]         v_avg;

    // Clamp a wide signed value into the 16-bit signed range.
    function automatic logic signed [ADC_W-1:0] sat16(input logic signed [IW-1:0] x);
        logic [IW-16:0] hi;
        hi = x[IW-1:15];
        if (hi == '0 || hi == '1) begin
            return $signed(x[15:0]);
        end
        return x[IW-1] ? 16'sh8000 : 16'sh7fff;
    endfunction

    always_comb begin
        accept = adc_valid && ready_q;
        v_en   = accept && (adc_chan == CH_VOLT);
        i_en   = accept && (adc_chan == CH_CURR);
        i_diff = $signed({1'b0, adc_data}) - $signed(17'(CUR_OFFSET));
        i_samp = sat16(IW'(i_diff));
        // An acceptance in the same cycle suppresses the timeout.
        hit    = (state_q == ACQ) && !accept && (idle_q == IDLE_HIT);
        clr    = (state_q == PUBLISH) || hit;
        done   = (state_q == ACQ) && (v_full || v_last) && (i_full || i_last);

        idle_d = idle_q;
        if (accept || (state_q == PUBLISH)) begin
            idle_d = '0;
        end else if (idle_q != IDLE_MAX) begin
            idle_d = idle_q + IDLE_W'(1);
        end

        v_avg   = ADC_W'(v_sum >> AVG_LOG2);
        i_shift = i_sum >>> AVG_LOG2;
        i_sat   = sat16(i_shift);
        i_ext   = 17'(i_sat);
        i_db    = i_sat;
        if ((i_ext <= DB) && (i_ext >= -DB)) begin
            i_db = '0;
        end
    end

    adc_chan_accum #(
        .N_LOG2    (AVG_LOG2),
        .IN_W      (ADC_W),
        .IS_SIGNED (1'b0),
        .ACC_W     (VW)
    ) u_vacc (
        .clk      (clk),
        .rst      (rst),
        .acc_en_i (v_en),
        .clr_i    (clr),
        .data_i   (adc_data),
        .sum_o    (v_sum),
        .full_o   (v_full),
        .last_o   (v_last)
    );

    adc_chan_accum #(
        .N_LOG2    (AVG_LOG2),
        .IN_W      (ADC_W),
        .IS_SIGNED (1'b1),
        .ACC_W     (IW)
    ) u_iacc (
        .clk      (clk),
        .rst      (rst),
        .acc_en_i (i_en),
        .clr_i    (clr),
        .data_i   (i_samp),
        .sum_o    (i_sum),
        .full_o   (i_full),
        .last_o   (i_last)
    );

    // Averages are captured in PUBLISH and presented on the following edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ACQ;
            ready_q     <= 1'b0;
            idle_q      <= '0;
            pub_q       <= 1'b0;
            v_avg_q     <= '0;
            i_avg_q     <= '0;
            volt_q      <= '0;
            curr_q      <= '0;
            out_valid_q <= 1'b0;
            stale_q     <= 1'b0;
        end else begin
            pub_q  <= 1'b0;
            idle_q <= idle_d;
            case (state_q)
                ACQ: begin
                    if (done) begin
                        state_q <= PUBLISH;
                        ready_q <= 1'b0;
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                PUBLISH: begin
                    state_q <= ACQ;
                    ready_q <= 1'b1;
                    v_avg_q <= v_avg;
                    i_avg_q <= i_db;
                    pub_q   <= 1'b1;
                end
                default: begin
                    state_q <= ACQ;
                    ready_q <= 1'b0;
                end
            endcase
            out_valid_q <= pub_q;
            if (pub_q) begin
                volt_q <= v_avg_q;
                curr_q <= i_avg_q;
            end
            if (pub_q) begin
                stale_q <= 1'b0;
            end else if (hit) begin
                stale_q <= 1'b1;
            end
        end
    end

    assign adc_ready = ready_q;
    assign voltage   = volt_q;
    assign current   = curr_q;
    assign out_valid = out_valid_q;
    assign stale     = stale_q;

endmodule

// File: tb/tb_adc_frontend_filter.sv
// Directed bench for adc_frontend_filter: hand-computed averages, handshake
// timing, surplus-sample drop, stale timeout and mid-window reset.
module tb_adc_frontend_filter;

    localparam int unsigned TMO = 300;

    logic               clk = 1'b0;
    logic               rst;
    logic               adc_valid;
    logic               adc_chan;
    logic [15:0]        adc_data;
    logic               adc_ready;
    logic [15:0]        voltage;
    logic signed [15:0] current;
    logic               out_valid;
    logic               stale;

    int n_vec  = 0;
    int n_miss = 0;
    int ov_cnt = 0;
    int ov_exp = 0;

    adc_frontend_filter #(
        .AVG_LOG2    (4),
        .CUR_OFFSET  (32768),
        .I_DEADBAND  (2),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .adc_valid (adc_valid),
        .adc_chan  (adc_chan),
        .adc_data  (adc_data),
        .adc_ready (adc_ready),
        .voltage   (voltage),
        .current   (current),
        .out_valid (out_valid),
        .stale     (stale)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (out_valid === 1'b1) ov_cnt++;
    end

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic send(input logic ch, input int d);
        int guard;
        @(negedge clk);
        adc_valid = 1'b1;
        adc_chan  = ch;
        adc_data  = 16'(d);
        guard     = 0;
        while (adc_ready !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 20) chk("ready_wait", 32'(adc_ready), 1);
        @(posedge clk);
    endtask

    task automatic pair(input int v, input int i);
        send(1'b0, v);
        send(1'b1, i);
    endtask

    // Called right after the edge that accepted the completing sample.
    task automatic expect_publish(input string tag, input int v, input int i);
        @(negedge clk);
        adc_valid = 1'b0;
        chk({tag, ".rdy_lo"}, 32'(adc_ready), 0);
        chk({tag, ".ov_t0"}, 32'(out_valid), 0);
        @(negedge clk);
        chk({tag, ".rdy_hi"}, 32'(adc_ready), 1);
        chk({tag, ".ov_t1"}, 32'(out_valid), 0);
        @(negedge clk);
        chk({tag, ".ov_t2"}, 32'(out_valid), 1);
        chk({tag, ".volt"}, 32'(voltage), v);
        chk({tag, ".curr"}, 32'(current), i);
        chk({tag, ".stale"}, 32'(stale), 0);
        @(negedge clk);
        chk({tag, ".ov_t3"}, 32'(out_valid), 0);
        ov_exp++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        adc_valid = 1'b0;
        adc_chan  = 1'b0;
        adc_data  = 16'd0;
        repeat (3) @(negedge clk);
        chk("rst.ready", 32'(adc_ready), 0);
        chk("rst.volt", 32'(voltage), 0);
        chk("rst.curr", 32'(current), 0);
        chk("rst.ov", 32'(out_valid), 0);
        chk("rst.stale", 32'(stale), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst.ready_rise", 32'(adc_ready), 1);

        for (int k = 0; k < 16; k++) pair(1000, 32818);
        expect_publish("nominal", 1000, 50);

        for (int k = 0; k < 16; k++) pair(500, (k < 8) ? 32758 : 32759);
        expect_publish("floor", 500, -10);

        for (int k = 0; k < 16; k++) pair(1234, 32770);
        expect_publish("db_pos", 1234, 0);

        for (int k = 0; k < 16; k++) pair(1, 32771);
        expect_publish("db_edge_pos", 1, 3);

        for (int k = 0; k < 16; k++) pair(2, 32765);
        expect_publish("db_edge_neg", 2, -3);

        for (int k = 0; k < 16; k++) pair(65535, 0);
        expect_publish("extreme", 65535, -32768);

        for (int k = 0; k < 16; k++) send(1'b0, 100 + k);
        repeat (4) send(1'b0, 9999);
        for (int k = 0; k < 16; k++) send(1'b1, 32868);
        expect_publish("surplus", 107, 100);

        send(1'b0, 7777);
        send(1'b1, 40000);
        send(1'b0, 7777);
        send(1'b1, 40000);
        send(1'b0, 7777);
        @(negedge clk);
        adc_valid = 1'b0;
        for (int k = 2; k <= int'(TMO) + 3; k++) begin
            @(negedge clk);
            if (k == int'(TMO) - 2) chk("tmo.early", 32'(stale), 0);
        end
        chk("tmo.stale", 32'(stale), 1);
        chk("tmo.volt_hold", 32'(voltage), 107);
        chk("tmo.curr_hold", 32'(current), 100);
        chk("tmo.no_ov", ov_cnt, ov_exp);

        for (int k = 0; k < 8; k++) pair(2000, 32798);
        #1;
        chk("tmo.stale_mid", 32'(stale), 1);
        for (int k = 0; k < 8; k++) pair(2000, 32798);
        expect_publish("post_tmo", 2000, 30);

        for (int k = 0; k < 5; k++) pair(3000, 33000);
        @(negedge clk);
        adc_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("mid_rst.volt", 32'(voltage), 0);
        chk("mid_rst.curr", 32'(current), 0);
        chk("mid_rst.ready", 32'(adc_ready), 0);
        chk("mid_rst.ov", 32'(out_valid), 0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 16; k++) pair(400, 32718);
        chk("mid_rst.no_early", ov_cnt, ov_exp);
        expect_publish("post_rst", 400, -50);

        @(negedge clk);
        chk("ov_total", ov_cnt, ov_exp);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
